rsnn_param_load_ctrl: RTL and testbench

- Sequencer for loading the RSNN weight/parameter shift memory: 216 weight bits followed by 96 neuron-parameter bits, 312 total.
- Accepts a serial bitstream from the host over a valid/ready handshake and drives the memory's shift enable and serial data.
- Counts bits, flags load completion and errors, and gates the network run-enable until a complete, valid parameter set is present.
- Sits between the synchronized host inputs and the serial memory / RSNN core, replacing ad-hoc load sequencing.

---
 rtl/rsnn_pkg.sv | 13 +
 rtl/rsnn_edge_detect.sv | 22 ++
 rtl/rsnn_param_load_ctrl.sv | 96 +++++++++
 tb/tb_rsnn_param_load_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rsnn_pkg.sv
// Shared constants for the RSNN parameter-load path.
// Memory layout: weights first, then neuron parameters.
package rsnn_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int RSNN_WEIGHT_BITS = 216;
    localparam int RSNN_PARAM_BITS  = 96;
    localparam int RSNN_TOTAL_BITS  = RSNN_WEIGHT_BITS + RSNN_PARAM_BITS;

endpackage

// File: rtl/rsnn_edge_detect.sv
// Registered rising-edge detector for a synchronized strobe.
// The history bit freezes with en so an edge seen while frozen fires on resume.
module rsnn_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            din_q <= 1'b0;
        else if (en)
            din_q <= din;
    end

    assign rise = din & ~din_q & en;

endmodule

// File: rtl/rsnn_param_load_ctrl.sv
// Serial load sequencer for the RSNN weight/parameter shift memory.
// Gates the network run-enable until a complete parameter set is present.
module rsnn_param_load_ctrl
    import rsnn_pkg::*;
#(
    parameter int TOTAL_BITS = RSNN_TOTAL_BITS,
    parameter int CNT_W      = 9,
    parameter int TIMEOUT    = 1023,
    parameter int TO_W       = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load_params,
    input  logic             host_valid,
    input  logic             host_bit,
    output logic             host_ready,
    output logic             shift_en,
    output logic             shift_bit,
    output logic [CNT_W-1:0] bit_count,
    output logic             busy,
    output logic             end_writing,
    output logic             params_valid,
    output logic             load_error,
    input  logic             run_request,
    output logic             rsnn_run_en
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOTAL_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL_BITS);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);

    logic [1:0]      state;
    logic [TO_W-1:0] to_cnt;
    logic            start;
    logic            xfer;
    logic            last_xfer;

    rsnn_edge_detect u_load_edge (
        .clk   (clk),
        .reset (reset),
        .en    (enable),
        .din   (load_params),
        .rise  (start)
    );

    // A restart cycle never accepts data; the bit would belong to the old load.
    assign busy       = (state == ST_SHIFT);
    assign host_ready = busy & enable & ~start;
    assign xfer       = host_valid & host_ready;
    assign shift_en   = xfer;
    assign shift_bit  = host_bit & xfer;
    assign last_xfer  = xfer & (bit_count == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            bit_count    <= '0;
            to_cnt       <= '0;
            end_writing  <= 1'b0;
            params_valid <= 1'b0;
            load_error   <= 1'b0;
            rsnn_run_en  <= 1'b0;
        end else begin
            end_writing <= last_xfer;
            rsnn_run_en <= params_valid & run_request & enable
                         & ~busy & ~start;
            if (start) begin
                state        <= ST_SHIFT;
                bit_count    <= '0;
                to_cnt       <= '0;
                params_valid <= 1'b0;
                load_error   <= 1'b0;
            end else if (enable && busy) begin
                if (xfer) begin
                    to_cnt <= '0;
                    if (last_xfer) begin
                        state        <= ST_DONE;
                        bit_count    <= CNT_FULL;
                        params_valid <= 1'b1;
                    end else begin
                        bit_count <= bit_count + 1'b1;
                    end
                end else if (to_cnt >= TO_LAST) begin
                    state      <= ST_IDLE;
                    to_cnt     <= TO_MAX;
                    load_error <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rsnn_param_load_ctrl.sv
// Directed bench for rsnn_param_load_ctrl.
// Inputs change 1ns after posedge; outputs are sampled at negedge.
module tb_rsnn_param_load_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       load_params;
    logic       host_valid;
    logic       host_bit;
    logic       host_ready;
    logic       shift_en;
    logic       shift_bit;
    logic [8:0] bit_count;
    logic       busy;
    logic       end_writing;
    logic       params_valid;
    logic       load_error;
    logic       run_request;
    logic       rsnn_run_en;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;
    int mism   = 0;
    int bad_en = 0;
    int ew_cnt = 0;

    rsnn_param_load_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .load_params  (load_params),
        .host_valid   (host_valid),
        .host_bit     (host_bit),
        .host_ready   (host_ready),
        .shift_en     (shift_en),
        .shift_bit    (shift_bit),
        .bit_count    (bit_count),
        .busy         (busy),
        .end_writing  (end_writing),
        .params_valid (params_valid),
        .load_error   (load_error),
        .run_request  (run_request),
        .rsnn_run_en  (rsnn_run_en)
    );

    always #5 clk = ~clk;

    function automatic logic pat(input int i);
        return logic'((i % 3 == 0) ^ ((i / 5) % 2 == 1));
    endfunction

    always @(negedge clk) begin
        if (shift_en) begin
            if (shift_bit !== pat(xfers)) mism++;
            if (!enable) bad_en++;
            xfers++;
        end
        if (end_writing) ew_cnt++;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        xfers  = 0;
        mism   = 0;
        bad_en = 0;
        ew_cnt = 0;
    endtask

    task automatic start_load();
        host_valid  = 1'b0;
        load_params = 1'b1;
        tick();
        load_params = 1'b0;
        clear_mon();
    endtask

    // Sends n bits; freezes enable for 5 cycles once freeze_at bits are in.
    task automatic run_bits(input int n, input bit toggle, input int freeze_at);
        int cyc = 0;
        int fz  = 0;
        while (xfers < n && cyc < 3000) begin
            host_valid = toggle ? ~cyc[0] : 1'b1;
            if (freeze_at >= 0 && xfers == freeze_at && fz < 5) begin
                enable = 1'b0;
                fz++;
            end else begin
                enable = 1'b1;
            end
            host_bit = pat(xfers);
            tick();
            cyc++;
        end
        host_valid = 1'b0;
        enable     = 1'b1;
        if (cyc >= 3000) check("run_bits_budget", xfers, n);
    endtask

    task automatic check_done(input string tag);
        @(negedge clk);
        check({tag, "_end_writing"}, int'(end_writing), 1);
        check({tag, "_params_valid"}, int'(params_valid), 1);
        check({tag, "_bit_count"}, int'(bit_count), 312);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_load_error"}, int'(load_error), 0);
        host_valid = 1'b1;
        repeat (3) tick();
        host_valid = 1'b0;
        check({tag, "_xfers"}, xfers, 312);
        check({tag, "_bit_mism"}, mism, 0);
        check({tag, "_ew_pulses"}, ew_cnt, 1);
        check({tag, "_shift_frozen"}, bad_en, 0);
    endtask

    initial begin
        int cyc;
        reset       = 1'b0;
        enable      = 1'b1;
        load_params = 1'b0;
        host_valid  = 1'b0;
        host_bit    = 1'b0;
        run_request = 1'b0;
        #3;
        check("rst_busy", int'(busy), 0);
        check("rst_bit_count", int'(bit_count), 0);
        check("rst_params_valid", int'(params_valid), 0);
        check("rst_run_en", int'(rsnn_run_en), 0);
        tick();
        reset = 1'b1;
        host_valid = 1'b1;
        @(negedge clk);
        check("idle_no_shift", int'(shift_en), 0);
        check("idle_ready", int'(host_ready), 0);
        tick();

        // Full continuous load
        start_load();
        @(negedge clk);
        check("load1_busy", int'(busy), 1);
        check("load1_error", int'(load_error), 0);
        tick();
        run_bits(312, 1'b0, -1);
        check_done("load1");

        // Run gating
        run_request = 1'b1;
        @(negedge clk);
        check("run_lat0", int'(rsnn_run_en), 0);
        tick();
        @(negedge clk);
        check("run_on", int'(rsnn_run_en), 1);
        tick();
        load_params = 1'b1;
        tick();
        load_params = 1'b0;
        clear_mon();
        @(negedge clk);
        check("run_off_on_load", int'(rsnn_run_en), 0);
        check("run_busy", int'(busy), 1);
        check("run_pv_cleared", int'(params_valid), 0);
        tick();
        run_request = 1'b0;

        // Throttled load with a freeze at bit 100
        run_bits(312, 1'b1, 100);
        check_done("thr");

        // Timeout after 50 bits
        start_load();
        run_bits(50, 1'b0, -1);
        cyc = 0;
        while (!load_error && cyc < 1100) begin
            tick();
            cyc++;
        end
        check("to_cycles", cyc, 1023);
        @(negedge clk);
        check("to_busy", int'(busy), 0);
        check("to_params_valid", int'(params_valid), 0);
        check("to_bit_count", int'(bit_count), 50);
        host_valid = 1'b1;
        repeat (5) tick();
        host_valid = 1'b0;
        check("to_no_shift", xfers, 50);
        check("to_error_sticky", int'(load_error), 1);

        // Restart at bit 200
        start_load();
        run_bits(200, 1'b0, -1);
        load_params = 1'b1;
        host_valid  = 1'b1;
        host_bit    = 1'b1;
        @(negedge clk);
        check("rs_no_shift", int'(shift_en), 0);
        check("rs_no_ready", int'(host_ready), 0);
        tick();
        load_params = 1'b0;
        host_valid  = 1'b0;
        clear_mon();
        @(negedge clk);
        check("rs_bit_count", int'(bit_count), 0);
        check("rs_busy", int'(busy), 1);
        tick();
        run_bits(312, 1'b0, -1);
        check_done("rs");

        // Asynchronous reset at bit 150
        start_load();
        run_bits(150, 1'b0, -1);
        host_valid = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        check("ar_busy", int'(busy), 0);
        check("ar_bit_count", int'(bit_count), 0);
        check("ar_params_valid", int'(params_valid), 0);
        check("ar_host_ready", int'(host_ready), 0);
        check("ar_shift_en", int'(shift_en), 0);
        check("ar_end_writing", int'(end_writing), 0);
        host_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        start_load();
        run_bits(312, 1'b0, -1);
        check_done("ar");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
